// File: rtl/gray_align_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_align_queue_pkg : shared FSM encoding, entry type and parcel helpers   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package gray_align_queue_pkg;

  localparam int unsigned c_xlen     = 32;
  localparam int unsigned c_blk_size = 128;
  localparam int unsigned c_boffset  = $clog2(c_blk_size / 8);
  localparam int unsigned c_tagw     = c_xlen - c_boffset;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_REQ  = 3'd1,
    ST_LO_WAIT = 3'd2,
    ST_HI_REQ  = 3'd3,
    ST_HI_WAIT = 3'd4,
    ST_UC_RESP = 3'd5,
    ST_DRAIN   = 3'd6
  } align_state_e;

  // Entry layout for the default XLEN/BLK_SIZE configuration.
  typedef struct packed {
    logic                  valid;
    logic [c_tagw-1:0]     tag;
    logic [c_blk_size-1:0] data;
  } align_entry_t;

  function automatic logic f_is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_align_queue_parcel_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | align_parcel_sel : picks one 16/32-bit instruction from a lo/hi block pair  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module align_parcel_sel
  import gray_align_queue_pkg::*;
#(
  parameter int unsigned BLK_SIZE = 128,
  parameter bit          CMP_EN   = 1'b1
) (
  input  logic [BLK_SIZE-1:0]            i_lo_blk,
  input  logic [BLK_SIZE-1:0]            i_hi_blk,
  input  logic [$clog2(BLK_SIZE/16)-1:0] i_p,
  output logic [31:0]                    o_instr,
  output logic                           o_comp,
  output logic                           o_crossing
);

  localparam int c_parcels = BLK_SIZE / 16;
  localparam int c_pw      = $clog2(BLK_SIZE / 16);

  logic [15:0]     w_par [c_parcels];
  logic [15:0]     w_lo;
  logic [15:0]     w_up;
  logic [c_pw-1:0] w_p_next;
  logic            w_unused;

  always_comb begin
    for (int i = 0; i < c_parcels; i++) begin
      w_par[i] = i_lo_blk[i*16 +: 16];
    end
  end

  assign w_lo       = w_par[i_p];
  assign o_comp     = CMP_EN && f_is_rvc(w_lo);
  assign o_crossing = !o_comp && (&i_p);
  // The wrapped index is only used when the upper parcel stays in the lo block.
  assign w_p_next   = i_p + c_pw'(1);
  assign w_up       = o_crossing ? i_hi_blk[15:0] : w_par[w_p_next];
  assign o_instr    = o_comp ? {16'h0000, w_lo} : {w_up, w_lo};

  assign w_unused   = ^i_hi_blk[BLK_SIZE-1:16];

endmodule
`default_nettype wire

// File: rtl/gray_align_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gray_align_queue : fully-associative fetch block queue with parcel stitching|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module gray_align_queue
  import gray_align_queue_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BLK_SIZE = 128,
  parameter int unsigned DEPTH    = 4,
  parameter bit          CMP_EN   = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  input  logic [XLEN-1:0]     req_addr_i,
  input  logic                req_uncached_i,
  output logic                req_ready_o,
  output logic                res_valid_o,
  output logic [31:0]         res_instr_o,
  output logic                res_comp_o,
  output logic                miss_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_uncached_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_blk_i
);

  localparam int unsigned      c_boffset = $clog2(BLK_SIZE / 8);
  localparam int unsigned      c_tagw    = XLEN - c_boffset;
  localparam int unsigned      c_iw      = $clog2(DEPTH);
  localparam logic [c_iw-1:0]  c_last    = c_iw'(DEPTH - 1);

  align_state_e        r_state;
  logic [DEPTH-1:0]    r_valid;
  logic [c_tagw-1:0]   r_tag  [DEPTH];
  logic [BLK_SIZE-1:0] r_data [DEPTH];
  logic [c_iw-1:0]     r_ptr;
  logic [c_iw-1:0]     r_lo_idx;
  logic [XLEN-1:1]     r_addr;
  logic                r_uc;
  logic [BLK_SIZE-1:0] r_byp_lo;
  logic [BLK_SIZE-1:0] r_byp_hi;

  logic [c_tagw-1:0]   w_lo_tag, w_hi_tag, w_r_lo_tag, w_r_hi_tag, w_fill_tag;
  logic                w_lo_hit, w_hi_hit, w_hit;
  logic [c_iw-1:0]     w_lo_idx, w_hi_idx, w_vict;
  logic [31:0]         w_e_instr, w_b_instr;
  logic                w_e_comp, w_b_comp, w_e_cross, w_b_cross;
  logic [BLK_SIZE-1:0] w_b_lo;
  logic                w_wait, w_fill_we, w_byp_lo_we, w_byp_hi_we;
  logic                w_unused;

  function automatic logic [c_iw-1:0] f_next(input logic [c_iw-1:0] v);
    return (v == c_last) ? '0 : v + c_iw'(1);
  endfunction

  assign w_lo_tag   = req_addr_i[XLEN-1:c_boffset];
  assign w_hi_tag   = w_lo_tag + c_tagw'(1);
  assign w_r_lo_tag = r_addr[XLEN-1:c_boffset];
  assign w_r_hi_tag = w_r_lo_tag + c_tagw'(1);
  assign w_unused   = req_addr_i[0];

  always_comb begin
    w_lo_hit = 1'b0;
    w_hi_hit = 1'b0;
    w_lo_idx = '0;
    w_hi_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && (r_tag[i] == w_lo_tag)) begin
        w_lo_hit = 1'b1;
        w_lo_idx = c_iw'(i);
      end
      if (r_valid[i] && (r_tag[i] == w_hi_tag)) begin
        w_hi_hit = 1'b1;
        w_hi_idx = c_iw'(i);
      end
    end
  end

  align_parcel_sel #(.BLK_SIZE(BLK_SIZE), .CMP_EN(CMP_EN)) u_entry_sel (
    .i_lo_blk   (r_data[w_lo_idx]),
    .i_hi_blk   (r_data[w_hi_idx]),
    .i_p        (req_addr_i[c_boffset-1:1]),
    .o_instr    (w_e_instr),
    .o_comp     (w_e_comp),
    .o_crossing (w_e_cross)
  );

  // While a lo block is arriving, crossing is decoded straight from memory data.
  assign w_b_lo = (r_state == ST_LO_WAIT) ? mem_res_blk_i : r_byp_lo;

  align_parcel_sel #(.BLK_SIZE(BLK_SIZE), .CMP_EN(CMP_EN)) u_refill_sel (
    .i_lo_blk   (w_b_lo),
    .i_hi_blk   (r_byp_hi),
    .i_p        (r_addr[c_boffset-1:1]),
    .o_instr    (w_b_instr),
    .o_comp     (w_b_comp),
    .o_crossing (w_b_cross)
  );

  assign w_hit = w_lo_hit && (!w_e_cross || w_hi_hit);

  assign req_ready_o = !flush_i &&
                       (((r_state == ST_IDLE) && w_hit && !req_uncached_i) ||
                        (r_state == ST_UC_RESP));
  assign res_valid_o = req_valid_i && req_ready_o;
  assign res_instr_o = (r_state == ST_UC_RESP) ? w_b_instr : w_e_instr;
  assign res_comp_o  = res_valid_o && ((r_state == ST_UC_RESP) ? w_b_comp : w_e_comp);
  assign miss_o      = (r_state != ST_IDLE);

  assign mem_req_valid_o    = !flush_i && ((r_state == ST_LO_REQ) || (r_state == ST_HI_REQ));
  assign mem_req_addr_o     = {((r_state == ST_HI_REQ) ? w_r_hi_tag : w_r_lo_tag),
                               {c_boffset{1'b0}}};
  assign mem_req_uncached_o = mem_req_valid_o && r_uc;

  // The hi fill must never overwrite the entry holding its own lo block.
  assign w_vict = ((r_state == ST_HI_WAIT) && (r_ptr == r_lo_idx)) ? f_next(r_ptr) : r_ptr;

  assign w_wait      = (r_state == ST_LO_WAIT) || (r_state == ST_HI_WAIT);
  assign w_fill_we   = w_wait && mem_res_valid_i && !flush_i && !r_uc;
  assign w_fill_tag  = (r_state == ST_LO_WAIT) ? w_r_lo_tag : w_r_hi_tag;
  assign w_byp_lo_we = (r_state == ST_LO_WAIT) && mem_res_valid_i && !flush_i && r_uc;
  assign w_byp_hi_we = (r_state == ST_HI_WAIT) && mem_res_valid_i && !flush_i && r_uc;

  always_ff @(posedge clk_i) begin
    if (w_fill_we) begin
      r_tag[w_vict]  <= w_fill_tag;
      r_data[w_vict] <= mem_res_blk_i;
    end
    if (w_byp_lo_we) r_byp_lo <= mem_res_blk_i;
    if (w_byp_hi_we) r_byp_hi <= mem_res_blk_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_valid  <= '0;
      r_ptr    <= '0;
      r_lo_idx <= '0;
      r_addr   <= '0;
      r_uc     <= 1'b0;
    end else begin
      if (flush_i) begin
        r_valid <= '0;
      end else if (w_fill_we) begin
        r_valid[w_vict] <= 1'b1;
        r_ptr           <= f_next(w_vict);
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid_i && !flush_i && (!w_hit || req_uncached_i)) begin
            r_addr   <= req_addr_i[XLEN-1:1];
            r_uc     <= req_uncached_i;
            r_lo_idx <= w_lo_idx;
            r_state  <= (req_uncached_i || !w_lo_hit) ? ST_LO_REQ : ST_HI_REQ;
          end
        end
        ST_LO_REQ, ST_HI_REQ: begin
          if (flush_i)              r_state <= ST_IDLE;
          else if (mem_req_ready_i) r_state <= (r_state == ST_LO_REQ) ? ST_LO_WAIT : ST_HI_WAIT;
        end
        ST_LO_WAIT: begin
          if (flush_i) begin
            r_state <= mem_res_valid_i ? ST_IDLE : ST_DRAIN;
          end else if (mem_res_valid_i) begin
            if (!r_uc) r_lo_idx <= w_vict;
            if (w_b_cross) r_state <= ST_HI_REQ;
            else           r_state <= r_uc ? ST_UC_RESP : ST_IDLE;
          end
        end
        ST_HI_WAIT: begin
          if (flush_i)              r_state <= mem_res_valid_i ? ST_IDLE : ST_DRAIN;
          else if (mem_res_valid_i) r_state <= r_uc ? ST_UC_RESP : ST_IDLE;
        end
        ST_UC_RESP: r_state <= ST_IDLE;
        ST_DRAIN:   if (mem_res_valid_i) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_align_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gray_align_queue : directed scoreboard bench for gray_align_queue        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_gray_align_queue;

  localparam int unsigned MEM_LAT = 3;

  logic         clk;
  logic         rst_i;
  logic         flush_i;
  logic         req_valid_i;
  logic [31:0]  req_addr_i;
  logic         req_uncached_i;
  logic         req_ready_o;
  logic         res_valid_o;
  logic [31:0]  res_instr_o;
  logic         res_comp_o;
  logic         miss_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_req_uncached_o;
  logic         mem_res_valid_i;
  logic [127:0] mem_res_blk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0]  exp_res [$];   // {comp, instr}
  logic [32:0]  exp_mem [$];   // {uncached, addr}
  logic [127:0] mem_tbl [logic [31:0]];
  logic [32:0]  mon_e;
  logic [31:0]  rsp_addr;

  gray_align_queue #(.XLEN(32), .BLK_SIZE(128), .DEPTH(4), .CMP_EN(1'b1)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .req_valid_i        (req_valid_i),
    .req_addr_i         (req_addr_i),
    .req_uncached_i     (req_uncached_i),
    .req_ready_o        (req_ready_o),
    .res_valid_o        (res_valid_o),
    .res_instr_o        (res_instr_o),
    .res_comp_o         (res_comp_o),
    .miss_o             (miss_o),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_req_uncached_o (mem_req_uncached_o),
    .mem_res_valid_i    (mem_res_valid_i),
    .mem_res_blk_i      (mem_res_blk_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default memory image: word k of block A is {(A+4k)[15:0] | 3, 16'h0013}.
  function automatic logic [127:0] blk_of(input logic [31:0] a);
    logic [127:0] b;
    logic [31:0]  t;
    b = '0;
    if (mem_tbl.exists(a)) return mem_tbl[a];
    for (int k = 0; k < 4; k++) begin
      t = a + 32'(4 * k);
      b[k*32 +: 32] = {t[15:0] | 16'h0003, 16'h0013};
    end
    return b;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Output monitor: pops scoreboards whenever the DUT presents a result or a memory request.
  always @(negedge clk) begin
    if (!rst_i && res_valid_o) begin
      n_checks++;
      if (exp_res.size() == 0) begin
        n_errors++;
        $display("FAIL res_unexpected: got instr=%h comp=%b, required no response", res_instr_o, res_comp_o);
      end else begin
        mon_e = exp_res.pop_front();
        if ({res_comp_o, res_instr_o} !== mon_e) begin
          n_errors++;
          $display("FAIL res_data: got instr=%h comp=%b, required instr=%h comp=%b",
                   res_instr_o, res_comp_o, mon_e[31:0], mon_e[32]);
        end
      end
    end
    if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
      n_checks++;
      if (exp_mem.size() == 0) begin
        n_errors++;
        $display("FAIL mem_unexpected: got addr=%h uc=%b, required no request", mem_req_addr_o, mem_req_uncached_o);
      end else begin
        mon_e = exp_mem.pop_front();
        if ({mem_req_uncached_o, mem_req_addr_o} !== mon_e) begin
          n_errors++;
          $display("FAIL mem_req: got addr=%h uc=%b, required addr=%h uc=%b",
                   mem_req_addr_o, mem_req_uncached_o, mon_e[31:0], mon_e[32]);
        end
      end
    end
  end

  // Lower-level memory: one block per accepted request, MEM_LAT cycles later.
  initial begin
    mem_res_valid_i = 1'b0;
    mem_res_blk_i   = '0;
    forever begin
      @(negedge clk);
      if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
        rsp_addr = mem_req_addr_o;
        @(posedge clk);
        repeat (MEM_LAT - 1) @(posedge clk);
        #1;
        mem_res_valid_i = 1'b1;
        mem_res_blk_i   = blk_of(rsp_addr);
        @(posedge clk);
        #1;
        mem_res_valid_i = 1'b0;
      end
    end
  end

  // Issues one request and holds it until accepted; ewait < 0 skips the latency check.
  task automatic fetch(input logic [31:0] pc, input logic uc, input logic [31:0] ei,
                       input logic ec, input int ewait);
    int w;
    bit ok;
    exp_res.push_back({ec, ei});
    req_valid_i    = 1'b1;
    req_addr_i     = pc;
    req_uncached_i = uc;
    w  = 0;
    ok = 1'b0;
    while (w < 40) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
      w++;
    end
    @(posedge clk);
    #1;
    req_valid_i    = 1'b0;
    req_uncached_i = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL fetch_timeout: pc=%h got no accept within 40 cycles, required accept", pc);
    end else if (ewait >= 0) begin
      check1($sformatf("latency_pc_%h", pc), 32'(w), 32'(ewait));
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i          = 1'b1;
    flush_i        = 1'b0;
    req_valid_i    = 1'b0;
    req_addr_i     = '0;
    req_uncached_i = 1'b0;
    mem_req_ready_i = 1'b1;
    mem_tbl[32'h100] = {16'h0013, 80'h0, 32'h00000013};
    mem_tbl[32'h110] = 128'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    @(negedge clk);
    check1("reset_flags", {27'h0, miss_o, req_ready_o, res_valid_o, mem_req_valid_o, mem_req_uncached_o}, 32'h0);
    check1("reset_mem_addr", mem_req_addr_o, 32'h0);
    @(posedge clk);
    #1;

    // Single-block cached miss, then same-cycle hit.
    exp_mem.push_back({1'b0, 32'h100});
    fetch(32'h100, 1'b0, 32'h00000013, 1'b0, 5);
    fetch(32'h100, 1'b0, 32'h00000013, 1'b0, 0);

    // Flush in IDLE with a hitting request: nothing accepted, everything invalidated.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h100;
    flush_i     = 1'b1;
    @(negedge clk);
    check1("flush_ready", {31'h0, req_ready_o}, 32'h0);
    check1("flush_res_valid", {31'h0, res_valid_o}, 32'h0);
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;

    // Crossing miss on both blocks.
    exp_mem.push_back({1'b0, 32'h100});
    exp_mem.push_back({1'b0, 32'h110});
    fetch(32'h10E, 1'b0, 32'h00000013, 1'b0, 9);

    // Compressed parcel at the block end needs only the lo block.
    mem_tbl[32'h100] = {16'h4501, 80'h0, 32'h00000013};
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    exp_mem.push_back({1'b0, 32'h100});
    fetch(32'h10E, 1'b0, 32'h00004501, 1'b1, 5);
    fetch(32'h10E, 1'b0, 32'h00004501, 1'b1, 0);

    // Uncached fetch does not allocate.
    exp_mem.push_back({1'b1, 32'h2000});
    fetch(32'h2000, 1'b1, 32'h20030013, 1'b0, 5);
    exp_mem.push_back({1'b0, 32'h2000});
    fetch(32'h2000, 1'b0, 32'h20030013, 1'b0, 5);
    fetch(32'h2000, 1'b0, 32'h20030013, 1'b0, 0);

    // Flush during LO_WAIT: the late block is drained, not written.
    exp_mem.push_back({1'b0, 32'h300});
    req_valid_i = 1'b1;
    req_addr_i  = 32'h300;
    repeat (2) @(posedge clk);
    #1;
    flush_i     = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check1("drain_miss", {31'h0, miss_o}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check1("drain_idle", {31'h0, miss_o}, 32'h0);
    @(posedge clk);
    #1;
    exp_mem.push_back({1'b0, 32'h300});
    fetch(32'h300, 1'b0, 32'h03030013, 1'b0, 5);

    // Round-robin eviction over five sequential blocks.
    do_reset();
    begin
      logic [31:0] ea [5];
      logic [31:0] ei [5];
      ea = '{32'h000, 32'h010, 32'h020, 32'h030, 32'h040};
      ei = '{32'h00030013, 32'h00130013, 32'h00230013, 32'h00330013, 32'h00430013};
      for (int i = 0; i < 5; i++) begin
        exp_mem.push_back({1'b0, ea[i]});
        fetch(ea[i], 1'b0, ei[i], 1'b0, 5);
      end
    end
    fetch(32'h040, 1'b0, 32'h00430013, 1'b0, 0);
    exp_mem.push_back({1'b0, 32'h000});
    fetch(32'h000, 1'b0, 32'h00030013, 1'b0, 5);

    // Hi fill with the pointer on the lo entry must skip that entry.
    do_reset();
    begin
      logic [31:0] pa [4];
      logic [31:0] pi [4];
      pa = '{32'h000, 32'h020, 32'h030, 32'h050};
      pi = '{32'h00030013, 32'h00230013, 32'h00330013, 32'h00530013};
      for (int i = 0; i < 4; i++) begin
        exp_mem.push_back({1'b0, pa[i]});
        fetch(pa[i], 1'b0, pi[i], 1'b0, 5);
      end
    end
    exp_mem.push_back({1'b0, 32'h010});
    fetch(32'h00E, 1'b0, 32'h0013000F, 1'b0, 5);
    fetch(32'h00E, 1'b0, 32'h0013000F, 1'b0, 0);
    fetch(32'h000, 1'b0, 32'h00030013, 1'b0, 0);
    fetch(32'h010, 1'b0, 32'h00130013, 1'b0, 0);
    exp_mem.push_back({1'b0, 32'h020});
    fetch(32'h020, 1'b0, 32'h00230013, 1'b0, 5);

    repeat (6) @(posedge clk);
    #1;
    check1("res_queue_empty", 32'(exp_res.size()), 32'h0);
    check1("mem_queue_empty", 32'(exp_mem.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
